// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with optional 1-entry skid, NOP insertion and flush; latency 1 cycle.
// Backpressure: in_rdy registered (!skid valid) when SKID=1, combinational (!M.v | out_rdy) when SKID=0.
module pipe_stage_skid #(
    parameter int              DW           = 128,
    parameter int              SW           = 32,
    parameter logic [DW-1:0]   NOP_VAL      = '0,
    parameter int              SKID         = 1,
    parameter int              FLUSH_BUBBLE = 1,
    parameter int              SIDE_FOLLOW  = 0
) (
    input  logic          clk,
    input  logic          cpurst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_data,
    input  logic [SW-1:0] in_side,
    input  logic          bubble,
    input  logic          flush,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic [SW-1:0] out_side,
    output logic          out_bub,
    output logic [1:0]    occ
);

    logic          m_v, s_v;
    logic [DW-1:0] m_data, s_data;
    logic [SW-1:0] m_side, s_side;
    logic          m_bub, s_bub;
    logic [SW-1:0] side_q;

    logic          deq, enq;
    logic [DW-1:0] e_data;

    assign in_rdy   = (SKID != 0) ? !s_v : (!m_v || out_rdy);
    assign deq      = m_v && out_rdy;
    assign enq      = in_rdy && (in_vld || bubble);
    // A bubble enqueues a NOP and leaves in_data pending upstream.
    assign e_data   = bubble ? NOP_VAL : in_data;

    assign out_vld  = m_v;
    assign out_data = m_data;
    assign out_bub  = m_bub;
    assign out_side = (SIDE_FOLLOW != 0) ? m_side : side_q;
    assign occ      = {1'b0, m_v} + {1'b0, s_v};

    always_ff @(posedge clk) begin
        if (cpurst) begin
            m_v    <= 1'b0;
            m_data <= NOP_VAL;
            m_side <= '0;
            m_bub  <= 1'b0;
            s_v    <= 1'b0;
            s_data <= NOP_VAL;
            s_side <= '0;
            s_bub  <= 1'b0;
            side_q <= '0;
        end else begin
            side_q <= in_side;
            if (flush) begin
                s_v    <= 1'b0;
                m_v    <= (FLUSH_BUBBLE != 0);
                m_data <= NOP_VAL;
                m_side <= in_side;
                m_bub  <= 1'b1;
            end else if (deq && s_v) begin
                m_v    <= 1'b1;
                m_data <= s_data;
                m_side <= s_side;
                m_bub  <= s_bub;
                s_v    <= enq;
                if (enq) begin
                    s_data <= e_data;
                    s_side <= in_side;
                    s_bub  <= bubble;
                end
            end else if (enq && (!m_v || deq)) begin
                m_v    <= 1'b1;
                m_data <= e_data;
                m_side <= in_side;
                m_bub  <= bubble;
            end else if (enq && (SKID != 0)) begin
                // Head is stalled: park the new entry in the skid slot.
                s_v    <= 1'b1;
                s_data <= e_data;
                s_side <= in_side;
                s_bub  <= bubble;
            end else if (deq) begin
                m_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two configurations driven with shared stimulus, checked against FIFO models.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld, bubble, flush, out_rdy;
    logic [15:0] in_data;
    logic [11:0] in_side;

    logic        a_in_rdy, a_out_vld, a_out_bub;
    logic [15:0] a_out_data;
    logic [11:0] a_out_side;
    logic [1:0]  a_occ;
    logic        b_in_rdy, b_out_vld, b_out_bub;
    logic [15:0] b_out_data;
    logic [11:0] b_out_side;
    logic [1:0]  b_occ;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DW(16), .SW(12), .NOP_VAL(16'h0000), .SKID(1), .FLUSH_BUBBLE(1), .SIDE_FOLLOW(0)) dut_a (
        .clk(clk), .cpurst(rst), .in_vld(in_vld), .in_rdy(a_in_rdy), .in_data(in_data),
        .in_side(in_side), .bubble(bubble), .flush(flush), .out_vld(a_out_vld), .out_rdy(out_rdy),
        .out_data(a_out_data), .out_side(a_out_side), .out_bub(a_out_bub), .occ(a_occ));

    pipe_stage_skid #(.DW(16), .SW(12), .NOP_VAL(16'hBEEF), .SKID(0), .FLUSH_BUBBLE(0), .SIDE_FOLLOW(1)) dut_b (
        .clk(clk), .cpurst(rst), .in_vld(in_vld), .in_rdy(b_in_rdy), .in_data(in_data),
        .in_side(in_side), .bubble(bubble), .flush(flush), .out_vld(b_out_vld), .out_rdy(out_rdy),
        .out_data(b_out_data), .out_side(b_out_side), .out_bub(b_out_bub), .occ(b_occ));

    // Reference: each stage is a FIFO of entries with capacity 2 (skid) or 1.
    typedef struct packed {
        logic [15:0] d;
        logic [11:0] s;
        logic        b;
    } ent_t;

    ent_t        mq [2][2];
    int          mc [2];
    logic [11:0] free_side;

    function automatic bit m_skid(int k);  return k == 0; endfunction
    function automatic bit m_fb(int k);    return k == 0; endfunction
    function automatic logic [15:0] m_nop(int k); return (k == 0) ? 16'h0000 : 16'hBEEF; endfunction
    function automatic bit m_rdy(int k);
        return m_skid(k) ? (mc[k] < 2) : (mc[k] == 0 || out_rdy);
    endfunction

    initial begin
        mc[0] = 0;
        mc[1] = 0;
        free_side = '0;
    end

    always @(posedge clk) begin
        bit rdy, deq, enq;
        for (int k = 0; k < 2; k++) begin
            rdy = m_rdy(k);
            if (rst) begin
                mc[k] = 0;
            end else if (flush) begin
                mc[k] = m_fb(k) ? 1 : 0;
                mq[k][0] = '{d: m_nop(k), s: in_side, b: 1'b1};
            end else begin
                deq = (mc[k] > 0) && out_rdy;
                enq = rdy && (in_vld || bubble);
                if (deq) begin
                    mq[k][0] = mq[k][1];
                    mc[k]    = mc[k] - 1;
                end
                if (enq) begin
                    mq[k][mc[k]] = '{d: (bubble ? m_nop(k) : in_data), s: in_side, b: bubble};
                    mc[k]        = mc[k] + 1;
                end
            end
        end
        free_side = rst ? 12'h000 : in_side;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_models();
        chk("a_occ", 32'(a_occ), 32'(mc[0]));
        chk("a_vld", 32'(a_out_vld), 32'(mc[0] > 0));
        chk("a_rdy", 32'(a_in_rdy), 32'(m_rdy(0)));
        chk("a_side", 32'(a_out_side), 32'(free_side));
        if (mc[0] > 0) begin
            chk("a_data", 32'(a_out_data), 32'(mq[0][0].d));
            chk("a_bub", 32'(a_out_bub), 32'(mq[0][0].b));
        end
        chk("b_occ", 32'(b_occ), 32'(mc[1]));
        chk("b_vld", 32'(b_out_vld), 32'(mc[1] > 0));
        chk("b_rdy", 32'(b_in_rdy), 32'(m_rdy(1)));
        if (mc[1] > 0) begin
            chk("b_data", 32'(b_out_data), 32'(mq[1][0].d));
            chk("b_bub", 32'(b_out_bub), 32'(mq[1][0].b));
            chk("b_side", 32'(b_out_side), 32'(mq[1][0].s));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_models();
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] d, input logic [11:0] s,
                         input logic bb, input logic fl, input logic ordy);
        rst = r; in_vld = v; in_data = d; in_side = s; bubble = bb; flush = fl; out_rdy = ordy;
    endtask

    typedef struct {
        logic        r, v, bb, fl, ordy;
        logic [15:0] d;
        logic        e_vld, e_bub, e_rdy;
        logic [15:0] e_data;
        logic [1:0]  e_occ;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic [15:0] d, logic bb, logic fl, logic ordy,
                                logic e_vld, logic [15:0] e_data, logic e_bub, logic [1:0] e_occ, logic e_rdy);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.bb = bb; t.fl = fl; t.ordy = ordy;
        t.e_vld = e_vld; t.e_data = e_data; t.e_bub = e_bub; t.e_occ = e_occ; t.e_rdy = e_rdy;
        return t;
    endfunction

    vec_t tbl [21];

    initial begin
        logic [11:0] side_v;
        drive(1'b1, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0, 1'b0);

        //          r  v  data     bb fl ordy  vld data     bub occ rdy
        tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 0,   0, 16'h0000, 0, 0, 1);
        tbl[1]  = mk(0, 1, 16'h0001, 0, 0, 1,   1, 16'h0001, 0, 1, 1);
        tbl[2]  = mk(0, 1, 16'h0002, 0, 0, 1,   1, 16'h0002, 0, 1, 1);
        tbl[3]  = mk(0, 1, 16'h0003, 0, 0, 1,   1, 16'h0003, 0, 1, 1);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 1,   0, 16'h0003, 0, 0, 1);
        tbl[5]  = mk(0, 1, 16'h000A, 0, 0, 0,   1, 16'h000A, 0, 1, 1);
        tbl[6]  = mk(0, 1, 16'h000B, 0, 0, 0,   1, 16'h000A, 0, 2, 0);
        tbl[7]  = mk(0, 1, 16'h000C, 0, 0, 0,   1, 16'h000A, 0, 2, 0);
        tbl[8]  = mk(0, 1, 16'h000C, 0, 0, 1,   1, 16'h000B, 0, 1, 1);
        tbl[9]  = mk(0, 1, 16'h000C, 0, 0, 1,   1, 16'h000C, 0, 1, 1);
        tbl[10] = mk(0, 0, 16'h0000, 0, 0, 1,   0, 16'h000C, 0, 0, 1);
        tbl[11] = mk(0, 1, 16'h0055, 1, 0, 0,   1, 16'h0000, 1, 1, 1);
        tbl[12] = mk(0, 1, 16'h0055, 0, 0, 1,   1, 16'h0055, 0, 1, 1);
        tbl[13] = mk(0, 0, 16'h0000, 0, 0, 0,   1, 16'h0055, 0, 1, 1);
        tbl[14] = mk(0, 1, 16'h0066, 0, 0, 0,   1, 16'h0055, 0, 2, 0);
        tbl[15] = mk(0, 1, 16'h0077, 0, 1, 0,   1, 16'h0000, 1, 1, 1);
        tbl[16] = mk(0, 0, 16'h0000, 0, 0, 1,   0, 16'h0000, 1, 0, 1);
        tbl[17] = mk(0, 1, 16'h0011, 0, 0, 0,   1, 16'h0011, 0, 1, 1);
        tbl[18] = mk(0, 1, 16'h0022, 0, 0, 0,   1, 16'h0011, 0, 2, 0);
        tbl[19] = mk(1, 1, 16'h0033, 0, 0, 0,   0, 16'h0000, 0, 0, 1);
        tbl[20] = mk(0, 0, 16'h0000, 0, 0, 1,   0, 16'h0000, 0, 0, 1);

        for (int i = 0; i < 21; i++) begin
            side_v = 12'h100 + 12'(i);
            drive(tbl[i].r, tbl[i].v, tbl[i].d, side_v, tbl[i].bb, tbl[i].fl, tbl[i].ordy);
            step();
            chk($sformatf("vec%0d_vld", i), 32'(a_out_vld), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d_data", i), 32'(a_out_data), 32'(tbl[i].e_data));
            if (tbl[i].e_vld || tbl[i].r)
                chk($sformatf("vec%0d_bub", i), 32'(a_out_bub), 32'(tbl[i].e_bub));
            chk($sformatf("vec%0d_occ", i), 32'(a_occ), 32'(tbl[i].e_occ));
            chk($sformatf("vec%0d_rdy", i), 32'(a_in_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_side", i), 32'(a_out_side), 32'(tbl[i].r ? 12'h000 : side_v));
        end

        // Side-channel binding, flush-to-empty and NOP insertion on the second configuration.
        drive(1, 0, 16'h0000, 12'h000, 0, 0, 0); step();
        drive(0, 1, 16'h0099, 12'h05A, 0, 0, 0); step();
        drive(0, 0, 16'h0000, 12'h100, 0, 0, 0); step();
        chk("seq_a_side_free", 32'(a_out_side), 32'h100);
        chk("seq_b_side_bound", 32'(b_out_side), 32'h05A);
        chk("seq_b_data_held", 32'(b_out_data), 32'h0099);
        drive(0, 1, 16'h0042, 12'h123, 0, 1, 0); step();
        chk("seq_b_flush_occ", 32'(b_occ), 32'h0);
        chk("seq_b_flush_vld", 32'(b_out_vld), 32'h0);
        chk("seq_a_flush_occ", 32'(a_occ), 32'h1);
        chk("seq_a_flush_bub", 32'(a_out_bub), 32'h1);
        drive(0, 1, 16'h0044, 12'h0C3, 1, 0, 0); step();
        chk("seq_b_nop_bub", 32'(b_out_bub), 32'h1);
        chk("seq_b_nop_data", 32'(b_out_data), 32'hBEEF);
        chk("seq_b_nop_side", 32'(b_out_side), 32'h0C3);
        chk("seq_b_rdy_stall", 32'(b_in_rdy), 32'h0);
        chk("seq_a_occ2", 32'(a_occ), 32'h2);

        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 16'($urandom),
                  12'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 9) < 6));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
